// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe
//   Widens an IN_W-bit immediate to OUT_W bits (sign, zero, upper, branch).
//   The result sits in an output register backed by one skid register, so
//   in_ready comes straight from a flop and never depends on out_ready.
module imm_extend_pipe #(
   parameter int IN_W     = 16,
   parameter int OUT_W    = 32,
   parameter int BR_SHIFT = 2
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_imm,
   input  logic [1:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic [1:0]       out_mode
);

   localparam int PAD_W = OUT_W - IN_W;

   typedef enum logic [1:0] {
      MODE_SEXT   = 2'd0,
      MODE_ZEXT   = 2'd1,
      MODE_UPPER  = 2'd2,
      MODE_BRANCH = 2'd3
   } mode_e;

   typedef struct packed {
      logic [1:0]       mode;
      logic [OUT_W-1:0] data;
   } entry_t;

   // Reject parameter sets for which the extension formulas are meaningless.
   if (IN_W < 1 || OUT_W <= IN_W || BR_SHIFT < 0 || BR_SHIFT >= OUT_W) begin : g_param_check
      $error("imm_extend_pipe: need 1 <= IN_W < OUT_W and 0 <= BR_SHIFT < OUT_W");
   end

   logic [OUT_W-1:0] sext_w;
   logic [OUT_W-1:0] ext_w;

   assign sext_w = {{PAD_W{in_imm[IN_W-1]}}, in_imm};

   // Extension arithmetic, evaluated on the input side before registering.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      ext_w = sext_w;
      case (mode_e'(in_mode))
         MODE_SEXT:   ext_w = sext_w;
         MODE_ZEXT:   ext_w = {{PAD_W{1'b0}}, in_imm};
         MODE_UPPER:  ext_w = {in_imm, {PAD_W{1'b0}}};
         MODE_BRANCH: ext_w = sext_w << BR_SHIFT;
         default:     ext_w = sext_w;
      endcase
   end

   entry_t main_q, main_d;
   entry_t skid_q, skid_d;
   logic   main_valid_q, main_valid_d;
   logic   skid_valid_q, skid_valid_d;
   logic   in_ready_q, in_ready_d;
   logic   accept;
   logic   main_free;

   assign accept    = in_valid && in_ready_q;
   // Main can load this edge when it is empty or its content is being taken.
   assign main_free = !main_valid_q || out_ready;

   // Next-state for the two-entry buffer; skid always drains into main first.
   always_comb begin
      main_d       = main_q;
      main_valid_d = main_valid_q;
      skid_d       = skid_q;
      skid_valid_d = skid_valid_q;
      if (main_free) begin
         if (skid_valid_q) begin
            main_d       = skid_q;
            main_valid_d = 1'b1;
            skid_valid_d = accept;
            if (accept) begin
               skid_d = '{mode: in_mode, data: ext_w};
            end
         end else begin
            main_valid_d = accept;
            if (accept) begin
               main_d = '{mode: in_mode, data: ext_w};
            end
         end
      end else if (accept) begin
         skid_d       = '{mode: in_mode, data: ext_w};
         skid_valid_d = 1'b1;
      end
      // in_ready is registered from the next skid state, keeping it off the out_ready path.
      in_ready_d = !skid_valid_d;
   end

   // State registers with asynchronous clear of both entries and their valids.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         // NOTE: only two small entries, so their data is cleared too; out_data must read 0 in reset.
         main_q       <= '0;
         skid_q       <= '0;
         main_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
         in_ready_q   <= 1'b1;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         main_q       <= main_d;
         skid_q       <= skid_d;
         main_valid_q <= main_valid_d;
         skid_valid_q <= skid_valid_d;
         in_ready_q   <= in_ready_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = main_valid_q;
   assign out_data  = main_q.data;
   assign out_mode  = main_q.mode;

endmodule
